intra_tu_walker: RTL and testbench

INTRA_TU_WALKER -- requirements
Module: intra_tu_walker

---
 rtl/intra_pkg.sv | 10 +
 rtl/intra_zscan_decode.sv | 24 ++
 rtl/intra_tu_walker.sv | 152 +++++++++++++++
 tb/tb_intra_tu_walker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared types and limits for the intra TU walker.
package intra_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} walk_state_t;

  localparam int MAX_CTU_LOG2 = 6;
  localparam int TU_LOG2_MIN  = 2;
  localparam int TU_LOG2_MAX  = 5;

endpackage

// File: rtl/intra_zscan_decode.sv
// Z-scan index de-interleave: even bits of k give the column, odd bits the row,
// both scaled by the TU size.
module intra_zscan_decode (
  input  logic [7:0]  k_i,
  input  logic [2:0]  shift_i,
  output logic [12:0] dx_o,
  output logic [12:0] dy_o
);

  logic [3:0] ev, od;

  always_comb begin
    ev = '0;
    od = '0;
    for (int i = 0; i < 4; i++) begin
      ev[i] = k_i[2*i];
      od[i] = k_i[2*i+1];
    end
  end

  assign dx_o = {9'd0, ev} << shift_i;
  assign dy_o = {9'd0, od} << shift_i;

endmodule

// File: rtl/intra_tu_walker.sv
// Walks the TUs of one CTU in z-scan order and hands each descriptor downstream.
// Build option: INTRA_TU_PIC_CLIP_EN skips TUs whose origin lies outside the picture.
module intra_tu_walker
  import intra_pkg::*;
#(
  parameter int MAX_CTU_LOG2 = intra_pkg::MAX_CTU_LOG2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  ctu_x,
  input  logic [8:0]  ctu_y,
  input  logic [2:0]  nMaxCUlog2,
  input  logic [2:0]  tuSize_in,
  input  logic [13:0] pic_width_in_samples,
  input  logic [12:0] pic_height_in_samples,
  output logic        tu_valid,
  input  logic        tu_ready,
  output logic [12:0] xTb,
  output logic [12:0] yTb,
  output logic [2:0]  tuSize,
  output logic        busy,
  output logic        done
);

`ifdef INTRA_TU_PIC_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  walk_state_t state_q, state_d;
  logic [7:0]  k_q, k_d, last_q, last_d;
  logic [12:0] bx_q, bx_d, by_q, by_d;
  logic [2:0]  tu_q, tu_d;
  logic [13:0] w_q, w_d;
  logic [12:0] h_q, h_d;
  logic [12:0] xtb_q, xtb_d, ytb_q, ytb_d;
  logic [2:0]  tsz_q, tsz_d;

  logic [2:0]  n_cl, tu_cl, diff;
  logic [8:0]  cnt;
  logic [12:0] dx, dy, cand_x, cand_y;
  logic        in_pic, last_idx;

  // Configuration clamp; out-of-range inputs are pulled into the legal window.
  always_comb begin
    n_cl = (nMaxCUlog2 > 3'(MAX_CTU_LOG2)) ? 3'(MAX_CTU_LOG2) : nMaxCUlog2;
    tu_cl = tuSize_in;
    if (tu_cl < 3'(TU_LOG2_MIN)) tu_cl = 3'(TU_LOG2_MIN);
    if (tu_cl > 3'(TU_LOG2_MAX)) tu_cl = 3'(TU_LOG2_MAX);
    if (tu_cl > n_cl)            tu_cl = n_cl;
    diff = n_cl - tu_cl;
    cnt  = 9'd1 << {diff, 1'b0};
  end

  intra_zscan_decode u_dec (
    .k_i     (k_q),
    .shift_i (tu_q),
    .dx_o    (dx),
    .dy_o    (dy)
  );

  assign cand_x   = bx_q + dx;
  assign cand_y   = by_q + dy;
  assign in_pic   = !CLIP_EN || (({1'b0, cand_x} < w_q) && (cand_y < h_q));
  assign last_idx = (k_q == last_q);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    last_d  = last_q;
    bx_d    = bx_q;
    by_d    = by_q;
    tu_d    = tu_q;
    w_d     = w_q;
    h_d     = h_q;
    xtb_d   = xtb_q;
    ytb_d   = ytb_q;
    tsz_d   = tsz_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        k_d     = '0;
        last_d  = 8'(cnt - 9'd1);
        bx_d    = {4'd0, ctu_x} << n_cl;
        by_d    = {4'd0, ctu_y} << n_cl;
        tu_d    = tu_cl;
        w_d     = pic_width_in_samples;
        h_d     = pic_height_in_samples;
      end
      SCAN: begin
        if (in_pic) begin
          state_d = EMIT;
          xtb_d   = cand_x;
          ytb_d   = cand_y;
          tsz_d   = tu_q;
        end else if (last_idx) begin
          state_d = FIN;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      EMIT: if (tu_ready) begin
        if (last_idx) begin
          state_d = FIN;
        end else begin
          state_d = SCAN;
          k_d     = k_q + 8'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      last_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      tu_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      xtb_q   <= '0;
      ytb_q   <= '0;
      tsz_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      tu_q    <= tu_d;
      w_q     <= w_d;
      h_q     <= h_d;
      xtb_q   <= xtb_d;
      ytb_q   <= ytb_d;
      tsz_q   <= tsz_d;
    end
  end

  assign tu_valid = (state_q == EMIT);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign xTb      = xtb_q;
  assign yTb      = ytb_q;
  assign tuSize   = tsz_q;

endmodule

// File: tb/tb_intra_tu_walker.sv
// Directed and randomized walks checked against a z-scan reference model.
module tb_intra_tu_walker;

`ifdef INTRA_TU_PIC_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, tu_ready;
  logic [8:0]  ctu_x, ctu_y;
  logic [2:0]  nMaxCUlog2, tuSize_in;
  logic [13:0] pic_width_in_samples;
  logic [12:0] pic_height_in_samples;
  logic        tu_valid, busy, done;
  logic [12:0] xTb, yTb;
  logic [2:0]  tuSize;

  int checks = 0;
  int errors = 0;

  intra_tu_walker dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .ctu_x                 (ctu_x),
    .ctu_y                 (ctu_y),
    .nMaxCUlog2            (nMaxCUlog2),
    .tuSize_in             (tuSize_in),
    .pic_width_in_samples  (pic_width_in_samples),
    .pic_height_in_samples (pic_height_in_samples),
    .tu_valid              (tu_valid),
    .tu_ready              (tu_ready),
    .xTb                   (xTb),
    .yTb                   (yTb),
    .tuSize                (tuSize),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 always ready, 1 random ready, 2 stall the first TU for 5 cycles.
  // abort_hs != 0 returns right after that many handshakes have been issued.
  task automatic do_walk(input int cx, input int cy, input int n, input int tin,
                         input int w, input int h, input int mode, input int abort_hs,
                         input string tag);
    int tu, nt, skip, dx, dy, x, y, cyc, prev, hs, stall;
    int qx[$], qy[$], qs[$];
    bit vld_p, rdy_p, fin;
    logic [12:0] px, py;
    tu = (tin > n) ? n : tin;
    nt = 1 << (2 * (n - tu));
    skip = 0;
    for (int k = 0; k < nt; k++) begin
      dx = 0;
      dy = 0;
      for (int b = 0; b < 4; b++) begin
        dx += ((k >> (2*b)) & 1) << b;
        dy += ((k >> (2*b + 1)) & 1) << b;
      end
      x = (cx << n) + (dx << tu);
      y = (cy << n) + (dy << tu);
      if (!CLIP || (x < w && y < h)) begin
        qx.push_back(x);
        qy.push_back(y);
        qs.push_back(skip);
        skip = 0;
      end else begin
        skip++;
      end
    end

    @(negedge clk);
    ctu_x = 9'(cx); ctu_y = 9'(cy);
    nMaxCUlog2 = 3'(n); tuSize_in = 3'(tin);
    pic_width_in_samples = 14'(w); pic_height_in_samples = 13'(h);
    start = 1'b1; tu_ready = 1'b0;
    cyc = 0; prev = 0; hs = 0; stall = 0;
    vld_p = 1'b0; rdy_p = 1'b0; fin = 1'b0; px = '0; py = '0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // Walk must ignore configuration changes after acceptance.
        start = 1'b0;
        ctu_x = 9'($urandom); ctu_y = 9'($urandom);
        nMaxCUlog2 = 3'($urandom); tuSize_in = 3'($urandom);
        pic_width_in_samples = 14'($urandom); pic_height_in_samples = 13'($urandom);
      end
      if (vld_p && !rdy_p) begin
        chk({tag, " hold_valid"}, 32'(tu_valid), 1);
        chk({tag, " hold_x"}, 32'(xTb), 32'(px));
        chk({tag, " hold_y"}, 32'(yTb), 32'(py));
      end else if (tu_valid) begin
        if (hs < qx.size()) begin
          chk({tag, " latency"}, cyc, prev + 2 + qs[hs]);
          chk({tag, " xTb"}, 32'(xTb), qx[hs]);
          chk({tag, " yTb"}, 32'(yTb), qy[hs]);
          chk({tag, " tuSize"}, 32'(tuSize), tu);
        end else begin
          chk({tag, " extra_tu"}, hs, qx.size());
        end
      end
      if (done) begin
        chk({tag, " done_cycle"}, cyc, prev + 1 + skip);
        chk({tag, " tu_count"}, hs, qx.size());
        fin = 1'b1;
      end
      case (mode)
        0: tu_ready = 1'b1;
        1: tu_ready = 1'($urandom_range(0, 1));
        default: begin
          tu_ready = !(tu_valid && stall < 5);
          if (tu_valid && stall < 5) stall++;
        end
      endcase
      if (!fin && tu_valid && tu_ready) begin
        hs++;
        prev = cyc;
      end
      vld_p = tu_valid; rdy_p = tu_ready; px = xTb; py = yTb;
      if (abort_hs != 0 && hs == abort_hs) return;
    end
    chk({tag, " finished"}, 32'(fin), 1);
    tu_ready = 1'b0;
    if (fin) begin
      @(negedge clk);
      chk({tag, " done_once"}, 32'(done), 0);
      chk({tag, " idle_after"}, 32'(busy), 0);
    end
  endtask

  int rn, rt, rw, rh, rcx, rcy, rmx, m;

  initial begin
    rst = 1'b1; start = 1'b0; tu_ready = 1'b0;
    ctu_x = '0; ctu_y = '0; nMaxCUlog2 = 3'd6; tuSize_in = 3'd5;
    pic_width_in_samples = '0; pic_height_in_samples = '0;
    repeat (3) @(negedge clk);
    chk("rst tu_valid", 32'(tu_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst xTb", 32'(xTb), 0);
    chk("rst yTb", 32'(yTb), 0);
    chk("rst tuSize", 32'(tuSize), 0);
    rst = 1'b0;

    do_walk(0, 0, 6, 5, 1920, 1080, 0, 0, "ctu00");
    do_walk(29, 16, 6, 4, 1920, 1080, 1, 0, "ctu29_16");
    do_walk(29, 16, 6, 4, 1920, 1072, 0, 0, "ctu29_16_h1072");
    do_walk(0, 0, 6, 5, 1920, 1080, 2, 0, "stall");
    do_walk(31, 0, 6, 5, 1920, 1080, 0, 0, "ctu31");
    do_walk(3, 2, 4, 5, 1920, 1080, 0, 0, "clamp");
    do_walk(0, 0, 6, 2, 1920, 1080, 1, 0, "max256");

    do_walk(0, 0, 6, 5, 1920, 1080, 0, 2, "rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid tu_valid", 32'(tu_valid), 0);
    chk("rst_mid busy", 32'(busy), 0);
    chk("rst_mid done", 32'(done), 0);
    rst = 1'b0; tu_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid no_done", 32'(done), 0);
      chk("rst_mid idle", 32'(busy), 0);
    end
    do_walk(0, 0, 6, 5, 1920, 1080, 0, 0, "restart");

    for (int i = 0; i < 12; i++) begin
      rn = int'($urandom_range(3, 6));
      rt = int'($urandom_range(2, 5));
      rw = int'($urandom_range(8, 2048));
      rh = int'($urandom_range(8, 2048));
      rmx = (8192 >> rn) - 1;
      if (rmx > 511) rmx = 511;
      m = (rw >> rn) + 1;
      if (m > rmx) m = rmx;
      rcx = int'($urandom_range(0, m));
      m = (rh >> rn) + 1;
      if (m > rmx) m = rmx;
      rcy = int'($urandom_range(0, m));
      do_walk(rcx, rcy, rn, rt, rw, rh, int'($urandom_range(0, 1)), 0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
